// File: rtl/sap_fetch_sequencer.sv
// SAP fetch stage: one-hot T-state ring, program counter and sticky halt.
// Strobes are decoded combinationally from the registered ring.
module sap_fetch_sequencer #(
    parameter int ADDR_W = 4,
    parameter int NUM_T  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_req,
    input  logic              instr_done,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              mar_load,
    output logic              pc_inc,
    output logic              ir_load,
    output logic [NUM_T-1:0]  t_state,
    output logic              halted
);

    typedef enum logic [0:0] {S_RUN, S_HALT} mode_t;

    mode_t             mode, mode_n;
    logic [NUM_T-1:0]  ring, ring_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              exec;

    localparam logic [NUM_T-1:0] T1 = NUM_T'(1);

    assign exec = |ring[NUM_T-1:3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode <= S_RUN;
            ring <= T1;
            pc   <= '0;
        end else begin
            mode <= mode_n;
            ring <= ring_n;
            pc   <= pc_n;
        end
    end

    always_comb begin
        mode_n = mode;
        ring_n = ring;
        pc_n   = pc;
        if (mode == S_RUN) begin
            ring_n = {ring[NUM_T-2:0], ring[NUM_T-1]};
            if (ring[1])
                pc_n = pc + 1'b1;
            // Jump lands even when the instruction also halts or ends early.
            if (exec) begin
                if (jump_en)
                    pc_n = jump_addr;
                if (halt_req) begin
                    ring_n = '0;
                    mode_n = S_HALT;
                end else if (instr_done) begin
                    ring_n = T1;
                end
            end
        end
    end

    assign pc_out   = pc;
    assign t_state  = ring;
    assign halted   = (mode == S_HALT);
    assign mar_load = ring[0];
    assign pc_inc   = ring[1];
    assign ir_load  = ring[2];

endmodule

// File: tb/tb_sap_fetch_sequencer.sv
// Directed bench for sap_fetch_sequencer: vector table plus hand sequences
// for free-run wrap, halt freeze and reset corner cases.
module tb_sap_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       halt_req, instr_done, jump_en;
    logic [3:0] jump_addr;
    logic [3:0] pc_out;
    logic       mar_load, pc_inc, ir_load, halted;
    logic [5:0] t_state;

    int checks   = 0;
    int failures = 0;

    sap_fetch_sequencer #(.ADDR_W(4), .NUM_T(6)) dut (
        .clk(clk), .reset(reset), .halt_req(halt_req), .instr_done(instr_done),
        .jump_en(jump_en), .jump_addr(jump_addr), .pc_out(pc_out),
        .mar_load(mar_load), .pc_inc(pc_inc), .ir_load(ir_load),
        .t_state(t_state), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, hr, id, je;
        logic [3:0] ja;
        logic [5:0] et;
        logic [3:0] epc;
        logic       eh;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic rst, input logic hr, input logic id,
                                input logic je, input logic [3:0] ja,
                                input logic [5:0] et, input logic [3:0] epc, input logic eh);
        vec_t v;
        v.rst = rst; v.hr = hr; v.id = id; v.je = je; v.ja = ja;
        v.et = et; v.epc = epc; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] et, input logic [3:0] epc,
                           input logic eh);
        chk({tag, " t_state"}, 32'(t_state), 32'(et));
        chk({tag, " pc_out"},  32'(pc_out),  32'(epc));
        chk({tag, " mar_load"}, 32'(mar_load), 32'(et[0]));
        chk({tag, " pc_inc"},  32'(pc_inc),  32'(et[1]));
        chk({tag, " ir_load"}, 32'(ir_load), 32'(et[2]));
        chk({tag, " halted"},  32'(halted),  32'(eh));
    endtask

    task automatic drive(input logic rst, input logic hr, input logic id,
                         input logic je, input logic [3:0] ja);
        reset = rst; halt_req = hr; instr_done = id; jump_en = je; jump_addr = ja;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        // rst hr id je ja   -> t_state     pc    halted
        vecs[0]  = mk(0, 0, 0, 0, 4'h0, 6'b000001, 4'h0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 4'h0, 6'b000001, 4'h0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 4'h0, 6'b000010, 4'h0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 4'h0, 6'b000100, 4'h1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 4'h0, 6'b001000, 4'h1, 0);
        vecs[5]  = mk(1, 0, 1, 0, 4'h0, 6'b000001, 4'h1, 0);
        vecs[6]  = mk(1, 0, 0, 0, 4'h0, 6'b000010, 4'h1, 0);
        vecs[7]  = mk(1, 0, 0, 0, 4'h0, 6'b000100, 4'h2, 0);
        vecs[8]  = mk(1, 0, 0, 0, 4'h0, 6'b001000, 4'h2, 0);
        vecs[9]  = mk(1, 0, 0, 0, 4'h0, 6'b010000, 4'h2, 0);
        vecs[10] = mk(1, 0, 0, 1, 4'hA, 6'b100000, 4'hA, 0);
        vecs[11] = mk(1, 0, 0, 0, 4'h0, 6'b000001, 4'hA, 0);
        vecs[12] = mk(1, 0, 1, 1, 4'h3, 6'b000010, 4'hA, 0);
        vecs[13] = mk(1, 1, 1, 1, 4'h3, 6'b000100, 4'hB, 0);
        vecs[14] = mk(1, 1, 1, 1, 4'h3, 6'b001000, 4'hB, 0);
        vecs[15] = mk(1, 0, 1, 1, 4'h5, 6'b000001, 4'h5, 0);
        vecs[16] = mk(1, 0, 0, 0, 4'h0, 6'b000010, 4'h5, 0);
        vecs[17] = mk(1, 0, 0, 0, 4'h0, 6'b000100, 4'h6, 0);
        vecs[18] = mk(1, 0, 0, 0, 4'h0, 6'b001000, 4'h6, 0);
        vecs[19] = mk(1, 1, 0, 1, 4'h9, 6'b000000, 4'h9, 1);
        vecs[20] = mk(1, 0, 1, 1, 4'h2, 6'b000000, 4'h9, 1);
        vecs[21] = mk(0, 0, 0, 0, 4'h0, 6'b000001, 4'h0, 0);

        #2;
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].hr, vecs[i].id, vecs[i].je, vecs[i].ja);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].et, vecs[i].epc, vecs[i].eh);
        end

        // Free run: period-6 ring, PC +1 per instruction, wraps after 16.
        do_reset();
        for (int k = 0; k <= 96; k++) begin
            chk($sformatf("run%0d t_state", k), 32'(t_state), 32'(6'b1 << (k % 6)));
            if (k % 6 == 0 || k % 6 == 1)
                chk($sformatf("run%0d pc_out", k), 32'(pc_out), 32'((k / 6) % 16));
            step();
        end

        // Halt in T4, then hammer the execute inputs for 20 clocks.
        do_reset();
        step(); step(); step();
        chk_all("pre_halt", 6'b001000, 4'h1, 1'b0);
        halt_req = 1'b1;
        step();
        chk_all("halt_entry", 6'b000000, 4'h1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, k[0], ~k[0], 1'b1, 4'(k + 3));
            step();
            chk_all($sformatf("halt%0d", k), 6'b000000, 4'h1, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        chk_all("halt_recover", 6'b000001, 4'h0, 1'b0);

        // Reset in T3 with a jump pending.
        reset = 1'b1;
        step(); step();
        chk_all("t3_before_rst", 6'b000100, 4'h1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h7);
        step();
        chk_all("t3_rst", 6'b000001, 4'h0, 1'b0);

        // Reset pulse entirely between edges must not act.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        step(); step();
        chk_all("glitch_pre", 6'b000100, 4'h1, 1'b0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        chk_all("glitch_post", 6'b001000, 4'h1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
